// File: rtl/seg_scan_if.sv
// Load/display bundle for the 7-segment scan controller.
// Names follow the controller's pin naming so board netlists map directly.
interface seg_scan_if #(
    parameter int NUM_DIG = 4
);
    logic [4*NUM_DIG-1:0] iDATA;
    logic                 iLOAD;
    logic                 iLZ_EN;
    logic [6:0]           oSEG;
    logic [NUM_DIG-1:0]   oAN;
    logic                 oFRAME;
    logic                 oACK;

    modport master (
        output iDATA, iLOAD, iLZ_EN,
        input  oSEG, oAN, oFRAME, oACK
    );

    modport slave (
        input  iDATA, iLOAD, iLZ_EN,
        output oSEG, oAN, oFRAME, oACK
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with blanking gaps,
// leading-zero suppression and frame-aligned double-buffered loads.
module seg_scan_ctrl #(
    parameter int NUM_DIG   = 4,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic      iCLK,
    input  logic      iRST,
    seg_scan_if.slave bus
);
    localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CW = $clog2(CNT_MAX);
    localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int DW = 4 * NUM_DIG;

    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] SHOW  = 1'b1;

    localparam logic [CW-1:0] SHOW_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIG - 1);

    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [DW-1:0]      disp;
    logic [DW-1:0]      pend;
    logic               pendVld;
    logic [6:0]         seg;
    logic [NUM_DIG-1:0] an;
    logic               frame;
    logic               ack;

    logic [3:0]         nib;
    logic [NUM_DIG-1:0] anSel;
    logic               allZero;
    logic               lzHit;
    logic [6:0]         showSeg;
    logic               boundary;

    assign bus.oSEG   = seg;
    assign bus.oAN    = an;
    assign bus.oFRAME = frame;
    assign bus.oACK   = ack;

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Walk from the MSD down so allZero covers nibbles top..i at digit i.
    always_comb begin
        nib     = 4'h0;
        anSel   = '1;
        allZero = 1'b1;
        lzHit   = 1'b0;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            allZero = allZero & (disp[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                nib      = disp[4*i +: 4];
                anSel[i] = 1'b0;
                lzHit    = allZero && (i > 0);
            end
        end
    end

    assign showSeg  = (bus.iLZ_EN && lzHit) ? 7'h7F : hexSeg(nib);
    assign boundary = (state == SHOW) && (cnt == SHOW_END)
                   && (idx == LAST_IDX);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= BLANK;
            cnt     <= '0;
            idx     <= '0;
            disp    <= '0;
            pend    <= '0;
            pendVld <= 1'b0;
            seg     <= 7'h7F;
            an      <= '1;
            frame   <= 1'b0;
            ack     <= 1'b0;
        end else begin
            frame <= 1'b0;
            ack   <= 1'b0;
            unique case (state)
                BLANK: begin
                    if (cnt == BLANK_END) begin
                        state <= SHOW;
                        cnt   <= '0;
                        an    <= anSel;
                        seg   <= showSeg;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_END) begin
                        state <= BLANK;
                        cnt   <= '0;
                        an    <= '1;
                        seg   <= 7'h7F;
                        idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= BLANK;
            endcase
            // A load on the boundary edge bypasses pend and wins over it.
            if (boundary) begin
                frame <= 1'b1;
                if (bus.iLOAD) begin
                    disp    <= bus.iDATA;
                    pendVld <= 1'b0;
                    ack     <= 1'b1;
                end else if (pendVld) begin
                    disp    <= pend;
                    pendVld <= 1'b0;
                    ack     <= 1'b1;
                end
            end else if (bus.iLOAD) begin
                pend    <= bus.iDATA;
                pendVld <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: vector table of frame loads plus
// hand sequences for load collisions and mid-frame reset.
module tb_seg_scan_ctrl;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIG(ND)) bus ();

    seg_scan_ctrl #(
        .NUM_DIG  (ND),
        .CLK_DIV  (4),
        .BLANK_CYC(2)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    typedef struct {
        int         dig;
        logic [6:0] seg;
    } slot_t;

    typedef struct {
        logic [15:0] data;
        bit          lz;
        bit          load;
        logic [27:0] segs;
    } vec_t;

    int      checks = 0;
    int      errors = 0;
    slot_t   q[$];
    bit      armed = 1'b0;
    logic [ND-1:0] prevAn = '1;
    vec_t    vecs[9];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pushSegs(input logic [27:0] segs);
        for (int i = 0; i < ND; i++) begin
            slot_t s;
            s.dig = i;
            s.seg = segs[7*i +: 7];
            q.push_back(s);
        end
    endtask

    task automatic waitFrame();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.oFRAME === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL frameTimeout got none want oFRAME");
        end
    endtask

    task automatic waitDrain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drainTimeout got %0d want 0", q.size());
            q.delete();
            armed = 1'b0;
        end
    endtask

    task automatic loadOnce(input logic [15:0] d);
        bus.iDATA = d;
        bus.iLOAD = 1'b1;
        @(negedge clk);
        bus.iLOAD = 1'b0;
    endtask

    // Scoreboard pops one slot at each blank->lit transition.
    always @(negedge clk) begin : mon
        slot_t      s;
        logic [3:0] eAn;
        if (armed && q.size() > 0 && bus.oAN != '1 && prevAn == '1) begin
            s   = q.pop_front();
            eAn = ~(4'b0001 << s.dig);
            check("slotAn", 32'(bus.oAN), 32'(eAn));
            check("slotSeg", 32'(bus.oSEG), 32'(s.seg));
            if (q.size() == 0) armed = 1'b0;
        end
        prevAn <= bus.oAN;
    end

    initial begin
        vecs[0] = '{16'h12AF, 1'b0, 1'b1, {7'h79, 7'h24, 7'h08, 7'h0E}};
        vecs[1] = '{16'h12AF, 1'b0, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
        vecs[2] = '{16'h0050, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
        vecs[3] = '{16'h0000, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{16'h0000, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{16'h8034, 1'b1, 1'b1, {7'h00, 7'h40, 7'h30, 7'h19}};
        vecs[6] = '{16'h0907, 1'b1, 1'b1, {7'h7F, 7'h10, 7'h40, 7'h78}};
        vecs[7] = '{16'h5BCD, 1'b0, 1'b1, {7'h12, 7'h03, 7'h46, 7'h21}};
        vecs[8] = '{16'hE6F0, 1'b1, 1'b1, {7'h06, 7'h02, 7'h0E, 7'h40}};

        bus.iDATA  = '0;
        bus.iLOAD  = 1'b1;
        bus.iLZ_EN = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        check("rstAn", 32'(bus.oAN), 32'hF);
        check("rstSeg", 32'(bus.oSEG), 32'h7F);
        check("rstFrame", 32'(bus.oFRAME), 32'h0);
        check("rstAck", 32'(bus.oACK), 32'h0);
        bus.iLOAD = 1'b0;
        rst       = 1'b0;

        // Scan timing from release: 2 blank + 4 lit per digit.
        for (int n = 0; n < 50; n++) begin
            int         ph;
            int         d;
            logic [3:0] eAn;
            logic [6:0] eSeg;
            ph   = n % 6;
            d    = (n / 6) % 4;
            eAn  = (ph < 2) ? 4'hF : ~(4'b0001 << d);
            eSeg = (ph < 2) ? 7'h7F : 7'h40;
            check("scanAn", 32'(bus.oAN), 32'(eAn));
            check("scanSeg", 32'(bus.oSEG), 32'(eSeg));
            check("scanFrame", 32'(bus.oFRAME),
                  32'((n > 0) && (n % 24 == 0)));
            check("scanAck", 32'(bus.oACK), 32'h0);
            @(negedge clk);
        end

        foreach (vecs[v]) begin
            waitFrame();
            repeat (3) @(negedge clk);
            bus.iLZ_EN = vecs[v].lz;
            if (vecs[v].load) loadOnce(vecs[v].data);
            pushSegs(vecs[v].segs);
            waitFrame();
            check("vecAck", 32'(bus.oACK), 32'(vecs[v].load));
            armed = 1'b1;
            waitDrain();
        end

        // Two loads in one frame: last wins, one ack.
        waitFrame();
        bus.iLZ_EN = 1'b0;
        repeat (2) @(negedge clk);
        loadOnce(16'h1111);
        repeat (3) @(negedge clk);
        loadOnce(16'h2222);
        pushSegs({4{7'h24}});
        waitFrame();
        check("dblAck", 32'(bus.oACK), 32'h1);
        armed = 1'b1;
        waitDrain();
        waitFrame();
        check("dblAckOnce", 32'(bus.oACK), 32'h0);

        // Pending 3333, then 4444 loaded exactly on the boundary edge.
        repeat (5) @(negedge clk);
        loadOnce(16'h3333);
        repeat (17) @(negedge clk);
        bus.iDATA = 16'h4444;
        bus.iLOAD = 1'b1;
        @(negedge clk);
        bus.iLOAD = 1'b0;
        check("bndFrame", 32'(bus.oFRAME), 32'h1);
        check("bndAck", 32'(bus.oACK), 32'h1);
        pushSegs({4{7'h19}});
        armed = 1'b1;
        waitDrain();
        waitFrame();
        check("bndPendClr", 32'(bus.oACK), 32'h0);

        // Reset while digit 2 is lit, with loads pending and on the reset edge.
        repeat (3) @(negedge clk);
        loadOnce(16'h7777);
        repeat (11) @(negedge clk);
        check("preRstAn", 32'(bus.oAN), 32'hB);
        rst       = 1'b1;
        bus.iDATA = 16'h9999;
        bus.iLOAD = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.iLOAD = 1'b0;
        check("midRstAn", 32'(bus.oAN), 32'hF);
        check("midRstSeg", 32'(bus.oSEG), 32'h7F);
        check("midRstAck", 32'(bus.oACK), 32'h0);
        @(negedge clk);
        check("restartBlank", 32'(bus.oAN), 32'hF);
        @(negedge clk);
        check("restartAn", 32'(bus.oAN), 32'hE);
        check("restartSeg", 32'(bus.oSEG), 32'h40);
        repeat (22) @(negedge clk);
        check("restartFrame", 32'(bus.oFRAME), 32'h1);
        check("restartNoAck", 32'(bus.oACK), 32'h0);
        pushSegs({4{7'h40}});
        armed = 1'b1;
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
